zx81_tape_saver: RTL

- Receiver for the ZX81/ZX80 SAVE signal. The CPU toggles the MIC line through the vsync generator.
- The block decodes the resulting pulse trains into bytes and writes them into a byte buffer. The HPS later uploads that buffer as a .p/.o file.
- It is the save-direction counterpart of the tape loader. It sits beside the tape RAM and is clocked from clk_sys, with timing gated by the 6.5 MHz pixel enable.

---
 rtl/zx81_tape_saver.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/zx81_tape_saver.sv
// ZX81/ZX80 SAVE receiver: decodes MIC pulse bursts into bytes for the tape buffer.
// Define TAPE_SAVE_NAME_STRIP_EN to drop the ZX81 filename bytes before they reach the buffer.
module zx81_tape_saver #(
  parameter int ADDR_W         = 14,
  parameter int GAP_TICKS      = 3900,
  parameter int EOF_TICKS      = 65000,
  parameter int ONE_MIN_PULSES = 6,
  parameter int MIN_PULSES     = 2
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              arm,
  input  logic              mic_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W:0]   byte_count,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              partial
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_BITS = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [15:0]     GAP_Q = 16'(GAP_TICKS);
  localparam logic [15:0]     EOF_Q = 16'(EOF_TICKS);
  localparam logic [3:0]      ONE_P = 4'(ONE_MIN_PULSES);
  localparam logic [3:0]      MIN_P = 4'(MIN_PULSES);
  localparam logic [ADDR_W:0] CAP   = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]  state;
  logic        mic_s1, mic_s2, mic_prev;
  logic        arm_prev;
  logic [15:0] quiet_cnt;
  logic [3:0]  pulse_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
`ifdef TAPE_SAVE_NAME_STRIP_EN
  logic        name_done;
`endif

  logic       rise, gap_hit, eof_hit, bit_val, bit_ok;
  logic [7:0] next_byte;

  always_comb begin
    rise      = ce & mic_s2 & ~mic_prev;
    gap_hit   = ce & (quiet_cnt == GAP_Q);
    eof_hit   = ce & (quiet_cnt == EOF_Q);
    bit_val   = (pulse_cnt >= ONE_P);
    bit_ok    = (pulse_cnt >= MIN_P);
    next_byte = {shift[6:0], bit_val};
  end

  assign busy = (state == S_BITS);
  assign done = (state == S_DONE);

  // Quiet time is measured on the synchronized level, clock-enabled by ce.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mic_s1    <= 1'b0;
      mic_s2    <= 1'b0;
      mic_prev  <= 1'b0;
      quiet_cnt <= '0;
    end else begin
      mic_s1 <= mic_in;
      mic_s2 <= mic_s1;
      if (ce) begin
        mic_prev <= mic_s2;
        if (rise)
          quiet_cnt <= '0;
        else if (!mic_s2 && quiet_cnt != 16'hFFFF)
          quiet_cnt <= quiet_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      arm_prev   <= 1'b0;
      pulse_cnt  <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      byte_count <= '0;
      overflow   <= 1'b0;
      partial    <= 1'b0;
`ifdef TAPE_SAVE_NAME_STRIP_EN
      name_done  <= 1'b0;
`endif
    end else begin
      wr_en    <= 1'b0;
      arm_prev <= arm;
      case (state)
        S_IDLE: begin
          if (arm && !arm_prev) begin
            byte_count <= '0;
            overflow   <= 1'b0;
            partial    <= 1'b0;
            pulse_cnt  <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
`ifdef TAPE_SAVE_NAME_STRIP_EN
            name_done  <= 1'b0;
`endif
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!arm)
            state <= S_IDLE;
          else if (rise) begin
            pulse_cnt <= 4'd1;
            state     <= S_BITS;
          end
        end
        S_BITS: begin
          if (!arm) begin
            pulse_cnt <= '0;
            bit_cnt   <= '0;
            state     <= S_IDLE;
          end else if (eof_hit) begin
            partial <= (bit_cnt != 3'd0);
            state   <= S_DONE;
          end else if (gap_hit) begin
            // The burst is classified before a coincident edge starts the next one.
            if (bit_ok) begin
              shift   <= next_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
`ifdef TAPE_SAVE_NAME_STRIP_EN
                if (!name_done)
                  name_done <= next_byte[7];
                else
`endif
                if (byte_count == CAP)
                  overflow <= 1'b1;
                else begin
                  wr_en      <= 1'b1;
                  wr_addr    <= byte_count[ADDR_W-1:0];
                  wr_data    <= next_byte;
                  byte_count <= byte_count + 1'b1;
                end
              end
            end
            pulse_cnt <= rise ? 4'd1 : 4'd0;
          end else if (rise && pulse_cnt != 4'hF) begin
            pulse_cnt <= pulse_cnt + 4'd1;
          end
        end
        default: begin
          if (!arm)
            state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
